// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_pkg
// Brief    : Shared drawing-state codes, sequencer FSM states and widths.
// Revision : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int c_ADDR_W = 11;
    localparam int c_DATA_W = 8;

    localparam logic [3:0] c_CREDENTIALS = 4'd1;
    localparam logic [3:0] c_TIME        = 4'd2;
    localparam logic [3:0] c_PLAYING     = 4'd3;
    localparam logic [3:0] c_DEAD        = 4'd4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_COMMIT  = 2'd3
    } seq_state_t;

    function automatic logic isValidState(input logic [3:0] code);
        return (code >= c_CREDENTIALS) && (code <= c_DEAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_rr_arbiter
// Brief    : Two-way round-robin grant for the framebuffer write port.
// Revision : 1.0 - initial release
// ============================================================================
module fb_rr_arbiter
    import draw_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    // High means layer 1 was served most recently, so layer 0 wins a tie.
    logic r_lastGrant;
    logic w_grant0;
    logic w_grant1;

    always_comb begin
        w_grant0 = enable && valid0 && (!valid1 || r_lastGrant);
        w_grant1 = enable && valid1 && (!valid0 || !r_lastGrant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= 1'b1;
        end else if (w_grant0) begin
            r_lastGrant <= 1'b0;
        end else if (w_grant1) begin
            r_lastGrant <= 1'b1;
        end
    end

    assign grant0 = w_grant0;
    assign grant1 = w_grant1;

endmodule
`default_nettype wire

// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : draw_sequencer
// Brief    : Clears the framebuffer on drawing-state changes and arbitrates
//            the text/sprite layers onto the single write port.
// Revision : 1.0 - initial release
// ============================================================================
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                DATA_W   = c_DATA_W,
    parameter int                FB_WORDS = 1200,
    parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_state,
    input  logic              vblank,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic [3:0]        active_state,
    output logic              clearing,
    output logic              state_changed
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    seq_state_t        r_state;
    seq_state_t        w_stateNext;
    logic [3:0]        r_active;
    logic [3:0]        r_pending;
    logic [3:0]        w_pendingNext;
    logic              w_reqValid;
    logic [ADDR_W-1:0] r_clearCnt;
    logic              r_fbWe;
    logic [ADDR_W-1:0] r_fbAddr;
    logic [DATA_W-1:0] r_fbData;
    logic              r_clearing;
    logic              r_stateChanged;
    logic              w_grant0;
    logic              w_grant1;

    fb_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .enable (r_state == ST_RUN),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (w_grant0),
        .grant1 (w_grant1)
    );

    always_comb begin
        w_stateNext   = r_state;
        w_pendingNext = r_pending;
        w_reqValid    = isValidState(req_state);
        case (r_state)
            ST_RUN: begin
                if (w_reqValid && (req_state != r_active)) begin
                    w_pendingNext = req_state;
                    w_stateNext   = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                // Abort and re-latch both outrank a coincident vblank.
                if (req_state == r_active) begin
                    w_stateNext = ST_RUN;
                end else if (w_reqValid && (req_state != r_pending)) begin
                    w_pendingNext = req_state;
                end else if (vblank) begin
                    w_stateNext = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_reqValid) begin
                    w_pendingNext = req_state;
                end
                if (r_clearCnt == c_LAST_ADDR) begin
                    w_stateNext = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_stateNext = ST_RUN;
            end
            default: begin
                w_stateNext = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_CLEAR;
            r_active       <= c_CREDENTIALS;
            r_pending      <= c_CREDENTIALS;
            r_clearCnt     <= '0;
            r_fbWe         <= 1'b0;
            r_fbAddr       <= '0;
            r_fbData       <= '0;
            r_clearing     <= 1'b0;
            r_stateChanged <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_pending      <= w_pendingNext;
            r_clearing     <= (w_stateNext == ST_CLEAR);
            r_stateChanged <= (r_state == ST_COMMIT);
            r_fbWe         <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_grant0) begin
                        r_fbWe   <= 1'b1;
                        r_fbAddr <= req0_addr;
                        r_fbData <= req0_data;
                    end else if (w_grant1) begin
                        r_fbWe   <= 1'b1;
                        r_fbAddr <= req1_addr;
                        r_fbData <= req1_data;
                    end
                end
                ST_WAIT_VB: begin
                    r_clearCnt <= '0;
                end
                ST_CLEAR: begin
                    r_fbWe     <= 1'b1;
                    r_fbAddr   <= r_clearCnt;
                    r_fbData   <= BG_COLOR;
                    r_clearCnt <= r_clearCnt + ADDR_W'(1);
                end
                ST_COMMIT: begin
                    r_active <= r_pending;
                end
                default: begin
                    r_fbWe <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready    = w_grant0;
    assign req1_ready    = w_grant1;
    assign fb_we         = r_fbWe;
    assign fb_addr       = r_fbAddr;
    assign fb_data       = r_fbData;
    assign active_state  = r_active;
    assign clearing      = r_clearing;
    assign state_changed = r_stateChanged;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sequencer
// Brief    : Self-checking bench for draw_sequencer against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_draw_sequencer;

    localparam int AW  = 11;
    localparam int DW  = 8;
    localparam int FBW = 16;

    localparam int P_SHOW   = 0;
    localparam int P_AWAIT  = 1;
    localparam int P_BLANK  = 2;
    localparam int P_COMMIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_state;
    logic          vblank;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data;
    logic [3:0]    active_state;
    logic          clearing;
    logic          state_changed;

    always #5 clk = ~clk;

    draw_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .FB_WORDS (FBW),
        .BG_COLOR (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_state     (req_state),
        .vblank        (vblank),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .req1_ready    (req1_ready),
        .fb_we         (fb_we),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .active_state  (active_state),
        .clearing      (clearing),
        .state_changed (state_changed)
    );

    int nAssert = 0;
    int nFail   = 0;

    // Reference model of the screen sequencing and layer sharing.
    int mPhase, mActive, mPending, mClearAddr, mLast;
    int mWe, mAddr, mData, mChg, mClearFlag;

    int   weCount, chgCount;
    logic sampR0, sampR1, lastAcc0, lastAcc1;

    typedef struct {
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } arb_vec_t;
    arb_vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isCode(input logic [3:0] c);
        return (c >= 4'd1) && (c <= 4'd4);
    endfunction

    task automatic modelReset();
        mPhase = P_BLANK; mClearAddr = 0; mActive = 1; mPending = 1; mLast = 1;
        mWe = 0; mAddr = 0; mData = 0; mChg = 0; mClearFlag = 0;
    endtask

    function automatic int pickLayer();
        if (mPhase != P_SHOW) return -1;
        if (req0_valid && req1_valid) return (mLast == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic modelEdge(input int pick);
        mChg = 0;
        if (rst) begin
            modelReset();
            return;
        end
        case (mPhase)
            P_SHOW: begin
                mWe = (pick >= 0) ? 1 : 0;
                if (pick == 0) begin mAddr = req0_addr; mData = req0_data; mLast = 0; end
                if (pick == 1) begin mAddr = req1_addr; mData = req1_data; mLast = 1; end
                if (isCode(req_state) && req_state != mActive) begin
                    mPending = req_state;
                    mPhase   = P_AWAIT;
                end
            end
            P_AWAIT: begin
                mWe = 0;
                if (req_state == mActive) mPhase = P_SHOW;
                else if (isCode(req_state) && req_state != mPending) mPending = req_state;
                else if (vblank) begin mPhase = P_BLANK; mClearAddr = 0; end
            end
            P_BLANK: begin
                mWe = 1; mAddr = mClearAddr; mData = 0;
                if (isCode(req_state)) mPending = req_state;
                mClearAddr++;
                if (mClearAddr == FBW) mPhase = P_COMMIT;
            end
            default: begin
                mWe = 0; mActive = mPending; mChg = 1; mPhase = P_SHOW;
            end
        endcase
        mClearFlag = (mPhase == P_BLANK) ? 1 : 0;
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_fb_we"}, fb_we, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data, 0);
        chk({tag, "_active"}, active_state, 1);
        chk({tag, "_clearing"}, clearing, 0);
        chk({tag, "_changed"}, state_changed, 0);
    endtask

    // One clock: check readiness before the edge, registered outputs after.
    task automatic step();
        int pick;
        #1;
        if (rst) modelReset();
        pick = pickLayer();
        sampR0 = req0_ready;
        sampR1 = req1_ready;
        lastAcc0 = req0_valid && req0_ready;
        lastAcc1 = req1_valid && req1_ready;
        chk("req0_ready", req0_ready, (pick == 0));
        chk("req1_ready", req1_ready, (pick == 1));
        @(posedge clk);
        modelEdge(pick);
        #1;
        chk("fb_we", fb_we, mWe);
        if (mWe != 0) begin
            chk("fb_addr", fb_addr, mAddr);
            chk("fb_data", fb_data, mData);
        end
        chk("active_state", active_state, mActive);
        chk("clearing", clearing, mClearFlag);
        chk("state_changed", state_changed, mChg);
        if (fb_we) weCount++;
        if (state_changed) chgCount++;
    endtask

    task automatic runUntilChange(input int maxCyc, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!state_changed && n < maxCyc);
        if (!state_changed) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic randLayers();
        if (!req0_valid || lastAcc0) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_addr  = AW'($urandom);
            req0_data  = DW'($urandom);
        end
        if (!req1_valid || lastAcc1) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_addr  = AW'($urandom);
            req1_data  = DW'($urandom);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{1, 1, 1, 0}; tbl[1] = '{1, 1, 0, 1};
        tbl[2] = '{1, 1, 1, 0}; tbl[3] = '{1, 1, 0, 1};
        tbl[4] = '{1, 0, 1, 0}; tbl[5] = '{1, 0, 1, 0};
        tbl[6] = '{1, 1, 0, 1}; tbl[7] = '{0, 1, 0, 1};
        tbl[8] = '{1, 1, 1, 0}; tbl[9] = '{0, 0, 0, 0};

        rst = 1'b1; req_state = 4'd1; vblank = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        lastAcc0 = 1'b0; lastAcc1 = 1'b0;
        modelReset();
        #2;
        checkReset("reset");
        step(); step();
        rst = 1'b0;

        // Power-up blanking without vblank.
        weCount = 0; chgCount = 0;
        runUntilChange(40, "powerup");
        chk("powerup_writes", weCount, FBW);
        chk("powerup_active", active_state, 1);
        chk("powerup_pulses", chgCount, 1);

        // Round-robin table; each layer holds its request until accepted.
        req0_addr = 11'd100; req0_data = 8'h10;
        req1_addr = 11'd200; req1_data = 8'h20;
        for (int i = 0; i < 10; i++) begin
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            step();
            chk("tbl_ready0", sampR0, tbl[i].r0);
            chk("tbl_ready1", sampR1, tbl[i].r1);
            if (sampR0) begin req0_addr++; req0_data++; end
            if (sampR1) begin req1_addr++; req1_data++; end
        end

        // Mode change waits for vblank.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req_state = 4'd3; weCount = 0; chgCount = 0;
        for (int i = 0; i < 20; i++) step();
        chk("wait_no_writes", weCount, 0);
        vblank = 1'b1; step(); vblank = 1'b0;
        runUntilChange(40, "to_playing");
        chk("playing_writes", weCount, FBW);
        chk("playing_active", active_state, 3);
        for (int i = 0; i < 3; i++) step();
        chk("playing_pulses", chgCount, 1);

        // Latest request wins while waiting for vblank.
        req_state = 4'd1; for (int i = 0; i < 3; i++) step();
        req_state = 4'd4; for (int i = 0; i < 3; i++) step();
        vblank = 1'b1; step(); vblank = 1'b0;
        runUntilChange(40, "to_dead");
        chk("dead_active", active_state, 4);

        // Returning to the active code before vblank aborts silently.
        weCount = 0; chgCount = 0;
        req_state = 4'd2; for (int i = 0; i < 3; i++) step();
        req_state = 4'd4; for (int i = 0; i < 3; i++) step();
        vblank = 1'b1; for (int i = 0; i < 5; i++) step(); vblank = 1'b0;
        chk("abort_writes", weCount, 0);
        chk("abort_pulses", chgCount, 0);
        chk("abort_active", active_state, 4);

        // Invalid codes leave the mode alone and arbitration running.
        req0_valid = 1'b1; req1_valid = 1'b1;
        req_state = 4'd7; for (int i = 0; i < 4; i++) step();
        req_state = 4'd0; for (int i = 0; i < 4; i++) step();
        chk("invalid_writes", weCount, 8);
        chk("invalid_pulses", chgCount, 0);
        chk("invalid_active", active_state, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset in the middle of a clear restarts it from address 0.
        req_state = 4'd2; vblank = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(fb_we && fb_addr == 11'd9) && n < 60);
        chk("reach_addr9", (fb_we && fb_addr == 11'd9), 1);
        vblank = 1'b0; req_state = 4'd1;
        rst = 1'b1;
        #1;
        checkReset("midclear");
        modelReset();
        step();
        rst = 1'b0;
        weCount = 0; chgCount = 0;
        runUntilChange(40, "restart");
        chk("restart_writes", weCount, FBW);
        chk("restart_active", active_state, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            randLayers();
            if ($urandom_range(0, 39) == 0) req_state = 4'($urandom_range(0, 7));
            vblank = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
